// File: rtl/lcd_timing_pkg.sv
// Shared types and default panel timing for the LCD video conduit driver.
package lcd_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE   = 800;
  localparam int unsigned DEF_H_FRONT    = 210;
  localparam int unsigned DEF_H_SYNC     = 1;
  localparam int unsigned DEF_H_BACK     = 45;
  localparam int unsigned DEF_H_TOTAL    = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;

  localparam int unsigned DEF_V_ACTIVE   = 480;
  localparam int unsigned DEF_V_FRONT    = 22;
  localparam int unsigned DEF_V_SYNC     = 1;
  localparam int unsigned DEF_V_BACK     = 22;
  localparam int unsigned DEF_V_TOTAL    = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int unsigned DEF_FIFO_DEPTH = 16;
  localparam int unsigned PIX_W          = 24;

  typedef enum logic [1:0] {IDLE, ALIGN, RUN} lcd_state_e;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef struct packed {
    logic   sof;
    pixel_t pixel;
  } fifo_entry_t;

endpackage

// File: rtl/video_pix_fifo.sv
// First-word-fall-through pixel FIFO; a pop frees a slot for a same-cycle push when full.
module video_pix_fifo
  import lcd_timing_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  fifo_entry_t              wdata,
  input  logic                     pop,
  output fifo_entry_t              rdata_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fifo_entry_t   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_pop;
  logic          do_push;

  assign empty_c = (count == '0);
  assign full_c  = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty_c;
  assign do_push = push && (!full_c || do_pop);
  assign rdata_c = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/lcd_timing_gen.sv
// DE-mode LCD timing generator fed by a buffered RGB888 stream, frame-aligned on start-of-frame.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FRONT    = DEF_H_FRONT,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BACK     = DEF_H_BACK,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FRONT    = DEF_V_FRONT,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BACK     = DEF_V_BACK,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic             enable,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_sof,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [PIX_W-1:0] video_RGB_OUT,
  output logic             video_HD,
  output logic             video_VD,
  output logic             video_DEN,
  output logic             frame_start,
  output logic             underflow
);

  localparam int unsigned H_TOTAL     = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL     = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HW          = $clog2(H_TOTAL);
  localparam int unsigned VW          = $clog2(V_TOTAL);
  localparam int unsigned CW          = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned H_ACT_START = H_SYNC + H_BACK;
  localparam int unsigned H_ACT_END   = H_ACT_START + H_ACTIVE;
  localparam int unsigned V_ACT_START = V_SYNC + V_BACK;
  localparam int unsigned V_ACT_END   = V_ACT_START + V_ACTIVE;

  lcd_state_e    state_q, state_d;
  logic [HW-1:0] h_cnt, h_d;
  logic [VW-1:0] v_cnt, v_d;
  logic          resync_q, resync_d;
  logic          hd_d, vd_d, den_d, fs_d, uf_d, ready_d;
  pixel_t        rgb_d;

  logic          running, in_active, frame_end, first_px;
  logic          fifo_push, fifo_pop, push_acc;
  logic [CW-1:0] cnt_d;

  fifo_entry_t   fifo_rdata_c;
  logic          fifo_full_c, fifo_empty_c;
  logic [CW-1:0] fifo_count;

  video_pix_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .push    (fifo_push),
    .wdata   ({pix_sof, pix_data}),
    .pop     (fifo_pop),
    .rdata_c (fifo_rdata_c),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c),
    .count   (fifo_count)
  );

  assign running   = (state_q != IDLE);
  assign in_active = (h_cnt >= HW'(H_ACT_START)) && (h_cnt < HW'(H_ACT_END)) &&
                     (v_cnt >= VW'(V_ACT_START)) && (v_cnt < VW'(V_ACT_END));
  assign frame_end = (h_cnt == HW'(H_TOTAL - 1)) && (v_cnt == VW'(V_TOTAL - 1));
  assign first_px  = (h_cnt == HW'(H_ACT_START)) && (v_cnt == VW'(V_ACT_START));

  always_comb begin
    state_d   = state_q;
    h_d       = h_cnt;
    v_d       = v_cnt;
    resync_d  = resync_q;
    uf_d      = underflow;
    hd_d      = 1'b1;
    vd_d      = 1'b1;
    den_d     = 1'b0;
    rgb_d     = '0;
    fifo_pop  = 1'b0;
    fifo_push = 1'b0;

    if (running) begin
      hd_d = (h_cnt >= HW'(H_SYNC));
      vd_d = (v_cnt >= VW'(V_SYNC));
      if (frame_end) begin
        h_d = '0;
        v_d = '0;
      end else if (h_cnt == HW'(H_TOTAL - 1)) begin
        h_d = '0;
        v_d = v_cnt + VW'(1);
      end else begin
        h_d = h_cnt + HW'(1);
      end
    end

    // RUN consumes one pixel per DEN cycle; other states flush non-sof heads.
    if (state_q == RUN && in_active) begin
      den_d = 1'b1;
      if (!fifo_empty_c) begin
        fifo_pop = 1'b1;
        rgb_d    = fifo_rdata_c.pixel;
        if (fifo_rdata_c.sof && !first_px) begin
          uf_d     = 1'b1;
          resync_d = 1'b1;
        end
      end else begin
        uf_d = 1'b1;
      end
    end else if (state_q != RUN && !fifo_empty_c && !fifo_rdata_c.sof) begin
      fifo_pop = 1'b1;
    end

    fifo_push = pix_valid && pix_ready && (state_q != IDLE || pix_sof);

    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d  = ALIGN;
          uf_d     = 1'b0;
          resync_d = 1'b0;
        end
      end
      ALIGN: begin
        if (frame_end) begin
          if (!enable)                                   state_d = IDLE;
          else if (!fifo_empty_c && fifo_rdata_c.sof)    state_d = RUN;
        end
      end
      RUN: begin
        if (frame_end) begin
          if (!enable) begin
            state_d = IDLE;
          end else if (resync_q) begin
            state_d  = ALIGN;
            resync_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // frame_start marks the cycle the counters sit at the origin, one ahead of the decoded outputs.
    fs_d     = (state_d != IDLE) && (h_d == '0) && (v_d == '0);
    push_acc = fifo_push && (!fifo_full_c || fifo_pop);
    cnt_d    = fifo_count + CW'(push_acc) - CW'(fifo_pop);
    ready_d  = (state_d == IDLE) || (cnt_d != CW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q       <= IDLE;
      h_cnt         <= '0;
      v_cnt         <= '0;
      resync_q      <= 1'b0;
      video_HD      <= 1'b1;
      video_VD      <= 1'b1;
      video_DEN     <= 1'b0;
      video_RGB_OUT <= '0;
      frame_start   <= 1'b0;
      underflow     <= 1'b0;
      pix_ready     <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_cnt         <= h_d;
      v_cnt         <= v_d;
      resync_q      <= resync_d;
      video_HD      <= hd_d;
      video_VD      <= vd_d;
      video_DEN     <= den_d;
      video_RGB_OUT <= rgb_d;
      frame_start   <= fs_d;
      underflow     <= uf_d;
      pix_ready     <= ready_d;
    end
  end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Self-checking bench for lcd_timing_gen using a reduced panel geometry and a frame-position model.
module tb_lcd_timing_gen;

  localparam int unsigned HA = 8, HF = 3, HS = 1, HB = 2, HT = HA + HF + HS + HB;
  localparam int unsigned VA = 4, VF = 2, VS = 1, VB = 1, VT = VA + VF + VS + VB;
  localparam int unsigned FRAME    = HT * VT;
  localparam int unsigned FPIX     = HA * VA;
  localparam int unsigned DEPTH    = 16;
  localparam int unsigned PRE      = 5;
  localparam int unsigned FIRST_FC = (VS + VB) * HT + HS + HB;

  logic        clk = 1'b0;
  logic        rst_n, enable;
  logic [23:0] pix_data;
  logic        pix_sof, pix_valid, pix_ready;
  logic [23:0] rgb;
  logic        hd, vd, den, fs, uf;

  always #5 clk = ~clk;

  lcd_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .enable        (enable),
    .pix_data      (pix_data),
    .pix_sof       (pix_sof),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .video_RGB_OUT (rgb),
    .video_HD      (hd),
    .video_VD      (vd),
    .video_DEN     (den),
    .frame_start   (fs),
    .underflow     (uf)
  );

  // Source: PRE filler pixels, then a running index with sof every FPIX pixels.
  int unsigned src_idx = 0;
  logic        src_on  = 1'b0;
  logic        xfer_seen = 1'b0;

  function automatic logic [24:0] src_word(int unsigned idx);
    if (idx < PRE) return {1'b0, 24'hAA0000 + 24'(idx)};
    return {(((idx - PRE) % FPIX) == 0), 24'(idx - PRE)};
  endfunction

  assign {pix_sof, pix_data} = src_word(src_idx);
  assign pix_valid = src_on;

  always @(posedge clk) xfer_seen = pix_valid && pix_ready;

  // Model: one frame-cycle counter, a pixel queue and a mode (0 idle, 1 align, 2 run).
  typedef struct packed { logic sof; logic [23:0] px; } ent_t;
  ent_t        q[$];
  int          m_mode = 0;
  int unsigned fc = 0;
  logic        m_uf = 1'b0, m_rs = 1'b0;
  logic        e_hd, e_vd, e_den, e_fs, e_uf, e_rdy;
  logic [23:0] e_rgb;

  always @(posedge clk) begin
    int unsigned h, v;
    logic act, head_sof, pop, last;
    int nmode;
    if (!rst_n) begin
      m_mode = 0; fc = 0; q.delete(); m_uf = 1'b0; m_rs = 1'b0;
      e_hd = 1'b1; e_vd = 1'b1; e_den = 1'b0; e_rgb = '0;
      e_fs = 1'b0; e_uf = 1'b0; e_rdy = 1'b0;
    end else begin
      h = fc % HT;
      v = fc / HT;
      act = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
      head_sof = (q.size() > 0) && q[0].sof;
      pop   = 1'b0;
      e_hd  = (m_mode == 0) || (h >= HS);
      e_vd  = (m_mode == 0) || (v >= VS);
      e_den = (m_mode == 2) && act;
      e_rgb = '0;
      if (e_den) begin
        if (q.size() > 0) begin
          e_rgb = q[0].px;
          pop   = 1'b1;
          if (q[0].sof && fc != FIRST_FC) begin m_uf = 1'b1; m_rs = 1'b1; end
        end else begin
          m_uf = 1'b1;
        end
      end else if (m_mode != 2 && q.size() > 0 && !q[0].sof) begin
        pop = 1'b1;
      end
      if (pop) void'(q.pop_front());
      if (pix_valid && e_rdy && (m_mode != 0 || pix_sof) && q.size() < int'(DEPTH))
        q.push_back({pix_sof, pix_data});
      last  = (fc == FRAME - 1);
      nmode = m_mode;
      if (m_mode == 0) begin
        if (enable) begin nmode = 1; m_uf = 1'b0; m_rs = 1'b0; end
      end else if (last) begin
        if (!enable)                    nmode = 0;
        else if (m_mode == 1 && head_sof) nmode = 2;
        else if (m_mode == 2 && m_rs) begin nmode = 1; m_rs = 1'b0; end
      end
      fc     = (m_mode == 0 || last) ? 0 : fc + 1;
      m_mode = nmode;
      e_fs   = (m_mode != 0) && (fc == 0);
      e_uf   = m_uf;
      e_rdy  = (m_mode == 0) || (q.size() < int'(DEPTH));
    end
  end

  int n_chk  = 0;
  int n_fail = 0;
  int cnt_hd, cnt_vd, cnt_den, cnt_fs;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clr_cnt();
    cnt_hd = 0; cnt_vd = 0; cnt_den = 0; cnt_fs = 0;
  endtask

  // One clock: advance source, compare every output against the model, update monitors.
  task automatic step();
    @(negedge clk);
    if (xfer_seen) src_idx++;
    chk("hd",    32'(hd),        32'(e_hd));
    chk("vd",    32'(vd),        32'(e_vd));
    chk("den",   32'(den),       32'(e_den));
    chk("rgb",   32'(rgb),       32'(e_rgb));
    chk("fs",    32'(fs),        32'(e_fs));
    chk("uf",    32'(uf),        32'(e_uf));
    chk("ready", 32'(pix_ready), 32'(e_rdy));
    if (hd === 1'b0)  cnt_hd++;
    if (vd === 1'b0)  cnt_vd++;
    if (den === 1'b1) cnt_den++;
    if (fs === 1'b1)  cnt_fs++;
  endtask

  task automatic wait_fs(input int unsigned budget, input string nm);
    int unsigned k = 0;
    do begin step(); k++; end while (fs !== 1'b1 && k < budget);
    chk(nm, 32'(fs), 32'd1);
  endtask

  initial begin
    logic        first_hd, first_vd;
    logic [23:0] r_first, r7, r8, r_last;
    int          dseen;
    rst_n = 1'b0; enable = 1'b0;
    clr_cnt();
    repeat (3) step();
    chk("rst_hd", 32'(hd), 32'd1);
    chk("rst_vd", 32'(vd), 32'd1);
    chk("rst_den", 32'(den), 32'd0);
    chk("rst_rgb", 32'(rgb), 32'd0);
    chk("rst_ready", 32'(pix_ready), 32'd0);
    chk("rst_uf", 32'(uf), 32'd0);

    // Idle with enable low.
    rst_n = 1'b1;
    clr_cnt();
    repeat (2000) step();
    chk("idle_fs_count", 32'(cnt_fs), 32'd0);
    chk("idle_hd_low", 32'(cnt_hd), 32'd0);
    chk("idle_vd_low", 32'(cnt_vd), 32'd0);
    chk("idle_den", 32'(cnt_den), 32'd0);
    chk("idle_ready", 32'(pix_ready), 32'd1);

    // Enable with PRE filler pixels ahead of the first sof.
    enable = 1'b1; src_on = 1'b1;
    wait_fs(4, "align_fs");
    clr_cnt();
    wait_fs(FRAME + 4, "run_fs");
    chk("align_den", 32'(cnt_den), 32'd0);
    chk("align_hd_low", 32'(cnt_hd), 32'(VT * HS));
    chk("align_vd_low", 32'(cnt_vd), 32'(HT * VS));
    chk("hd_before_fall", 32'(hd), 32'd1);

    // First RUN frame.
    clr_cnt(); dseen = 0; first_hd = 1'b1; first_vd = 1'b1;
    r_first = '1; r7 = '1; r8 = '1; r_last = '1;
    for (int k = 0; k < int'(FRAME); k++) begin
      step();
      if (k == 0) begin first_hd = hd; first_vd = vd; end
      if (den === 1'b1) begin
        if (dseen == 0) r_first = rgb;
        if (dseen == 7) r7 = rgb;
        if (dseen == 8) r8 = rgb;
        r_last = rgb;
        dseen++;
      end
    end
    chk("hd_fall_after_fs", 32'(first_hd), 32'd0);
    chk("vd_fall_after_fs", 32'(first_vd), 32'd0);
    chk("run_den_count", 32'(cnt_den), 32'(FPIX));
    chk("run_hd_low", 32'(cnt_hd), 32'(VT * HS));
    chk("run_vd_low", 32'(cnt_vd), 32'(HT * VS));
    chk("run_fs_count", 32'(cnt_fs), 32'd1);
    chk("first_pixel", 32'(r_first), 32'h000000);
    chk("line0_last", 32'(r7), 32'h000007);
    chk("line1_first", 32'(r8), 32'h000008);
    chk("frame_last", 32'(r_last), 32'h00001F);
    chk("run_uf", 32'(uf), 32'd0);

    // Source stall long enough to drain the FIFO during active lines.
    repeat (20) step();
    src_on = 1'b0;
    repeat (40) step();
    src_on = 1'b1;
    repeat (60) step();
    chk("uf_set", 32'(uf), 32'd1);
    clr_cnt();
    repeat (2 * FRAME) step();
    chk("stall_hd_low", 32'(cnt_hd), 32'(2 * VT * HS));
    chk("stall_vd_low", 32'(cnt_vd), 32'(2 * HT * VS));
    chk("uf_sticky", 32'(uf), 32'd1);

    // Drop enable mid-frame: frame completes, then idle.
    wait_fs(3 * FRAME, "pre_drop_fs");
    repeat (2 * HT + HS + HB + 3) step();
    enable = 1'b0;
    clr_cnt();
    repeat (FRAME) step();
    chk("drop_no_fs", 32'(cnt_fs), 32'd0);
    clr_cnt();
    repeat (300) step();
    chk("drop_idle_hd", 32'(cnt_hd), 32'd0);
    chk("drop_idle_den", 32'(cnt_den), 32'd0);
    chk("drop_idle_fs", 32'(cnt_fs), 32'd0);
    chk("drop_uf_held", 32'(uf), 32'd1);

    // Re-enable: underflow clears on the frame-boundary enable.
    enable = 1'b1;
    wait_fs(3, "realign_fs");
    chk("uf_cleared", 32'(uf), 32'd0);
    clr_cnt();
    repeat (4 * FRAME) step();
    chk("rerun_den_seen", 32'(cnt_den != 0), 32'd1);

    // Reset mid-frame.
    repeat (40) step();
    rst_n = 1'b0;
    step();
    chk("mrst_hd", 32'(hd), 32'd1);
    chk("mrst_vd", 32'(vd), 32'd1);
    chk("mrst_den", 32'(den), 32'd0);
    chk("mrst_rgb", 32'(rgb), 32'd0);
    chk("mrst_ready", 32'(pix_ready), 32'd0);
    chk("mrst_uf", 32'(uf), 32'd0);
    rst_n = 1'b1;
    repeat (3 * FRAME) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
